uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receive datapath that feeds the DATA/STAT/INSTAT register fields.
//  - Oversamples rx_i, deframes 8-bit characters and flags framing/parity errors.
//  - Buffers characters in a show-ahead FIFO that is popped on a DATA read.
//  - Sits between the pad synchroniser and the register block (regs).
// PARAMETERS
//  FIFO_DEPTH   8   RX FIFO entries; power of 2, >=2
//  OVERSAMPLE   16  ticks per bit; even, >=8
//  SYNC_STAGES  2   flops in the rx_i synchroniser; >=2
// PORTS
//  clk          in   1  single clock
//  rst          in   1  synchronous, active-high reset
//  rx_i         in   1  serial input, idle high, asynchronous
//  ctrl_rxen    in   1  CTRL.RXEN, receiver enable
//  ctrl_baud    in   2  CTRL.BAUD, index into BAUD_DIV table
//  lpmode_en    in   1  LPMODE.EN, use lpmode_div instead of table
//  lpmode_div   in   8  LPMODE.DIV, tick divisor minus 1
//  data_rd      in   1  1-cycle strobe: DATA register read, pops FIFO
//  data_fifo    out  8  FIFO head character (0 when empty)
//  data_ferr    out  1  head entry framing error (0 when empty)
//  data_perr    out  1  head entry parity error (0 when empty)
//  stat_rxe     out  1  FIFO non-empty (RX data available)
//  rx_busy      out  1  frame in progress (FSM != IDLE)
//  instat_rx    out  1  1-cycle pulse per character pushed
//  rx_ovr       out  1  1-cycle pulse: character dropped, FIFO full
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; FIFO empty; synchroniser flops=1.
//  Tick generator: 9-bit down-counter. Reload value:
//   - lpmode_en=1: lpmode_div (tick period = lpmode_div+1 clk)
//   - lpmode_en=0: BAUD_DIV[ctrl_baud]-1
//   Counter is held at its reload value while FSM=IDLE; it restarts on start-edge detect.
//  FSM, all sampling on ticks; the bit counter wraps at OVERSAMPLE:
//   - IDLE: synced rx 1->0 edge and ctrl_rxen=1 -> START.
//   - START: at tick OVERSAMPLE/2, rx=1 (glitch) -> IDLE with no push; rx=0 -> DATA.
//   - DATA: 8 samples, one every OVERSAMPLE ticks, LSB first -> PARITY or STOP.
//   - PARITY: 1 sample; perr = sample ^ (^data), even parity -> STOP.
//   - STOP: 1 sample; ferr = ~sample -> push, then IDLE.
//   - A STOP with ferr=1 still pushes, so a break pushes data=0x00, ferr=1.
//   - If rx is low on return to IDLE, no new start is detected until rx goes high.
//  Push: {perr,ferr,data} written on the same cycle as the stop sample; instat_rx pulses that cycle.
//  Full FIFO: the new character is dropped, FIFO is unchanged, rx_ovr pulses.
//    - Exception: if data_rd is high in the same cycle, pop and push both occur.
//  Pop: data_rd with FIFO empty is ignored.
//    - Head outputs update the cycle after a pop (registered show-ahead).
//  Simultaneous push+pop on an empty FIFO: push wins; the entry appears next cycle.
//  ctrl_rxen=0: FSM forced to IDLE next cycle, partial frame discarded, FIFO contents retained.
//  Changing ctrl_baud or lpmode mid-frame takes effect at the next counter reload; not guarded.
//  Pointers wrap mod FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: 11-bit frame (start, 8 data, even parity, stop).
//  UART_RX_PARITY_EN undefined:
//   - 10-bit frame; PARITY state is not built.
//   - perr stored as 0, so data_perr is constant 0.
// STRUCTURE
//  uart_pkg holds:
//   - BAUD_DIV[4] = '{27, 54, 163, 326} (50 MHz, 16x oversample)
//   - rx_entry_t struct {perr, ferr, data[7:0]}
//   - rx_state_e enum {IDLE, START, DATA, PARITY, STOP}
//  Sub-module uart_rx_fifo: synchronous show-ahead FIFO of rx_entry_t with push, pop, full, empty.
// TESTING
//  - Reset: lpmode_en=1, lpmode_div=3 (64 clk/bit). Send 0xA5, good parity, stop=1 -> data_fifo=0xA5, ferr=0, perr=0, stat_rxe=1, one instat_rx pulse.
//  - Pop: with 0xA5 at head, pulse data_rd -> stat_rxe=0 and data_fifo=0x00 next cycle; a second data_rd does nothing.
//  - Errors: send 0x3C with stop=0 -> ferr=1. Send 0x3C with bad parity -> perr=1 (perr=0 when parity is compiled out).
//  - Glitch: rx low for 20 clk at lpmode_div=3 -> no push, rx_busy returns to 0 within 40 clk.
//  - Overflow: push 9 characters 0x01..0x09 with no reads -> 1 rx_ovr pulse, reads return 0x01..0x08.
//    Repeat with data_rd coinciding with the 9th push -> no rx_ovr.
//  - Mid-frame: drop ctrl_rxen after 3 data bits -> rx_busy=0 next cycle, no push, earlier FIFO entries intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and baud table for the UART receive path.
package uart_pkg;

    // Tick divisors for 50 MHz with 16x oversampling
    localparam logic [8:0] BAUD_DIV [4] = '{9'd27, 9'd54, 9'd163, 9'd326};

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic [8:0] baud_reload(input logic [1:0] idx);
        return BAUD_DIV[idx] - 9'd1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead RX FIFO; head is driven purely from flops and reads as zero when empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  rx_entry_t wdata,
    output rx_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    rx_entry_t     mem_q [DEPTH];
    rx_entry_t     mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchroniser, tick generator, deframing FSM and RX FIFO.
// Define UART_RX_PARITY_EN for an 11-bit frame with an even parity bit.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       ctrl_rxen,
    input  logic [1:0] ctrl_baud,
    input  logic       lpmode_en,
    input  logic [7:0] lpmode_div,
    input  logic       data_rd,
    output logic [7:0] data_fifo,
    output logic       data_ferr,
    output logic       data_perr,
    output logic       stat_rxe,
    output logic       rx_busy,
    output logic       instat_rx,
    output logic       rx_ovr
);
    localparam int            SW       = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SUB_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q, rx_prev_d;
    rx_state_e              state_q, state_d;
    logic [8:0]             tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]          sub_cnt_q, sub_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             data_q, data_d;
`ifdef UART_RX_PARITY_EN
    logic                   perr_q, perr_d;
`endif
    logic                   rx_s, start_edge, tick, sample, push, full, empty;
    logic [8:0]             reload;
    rx_entry_t              push_entry, head;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = rx_prev_q & ~rx_s;
    assign reload     = lpmode_en ? {1'b0, lpmode_div} : baud_reload(ctrl_baud);
    assign tick       = (tick_cnt_q == '0);
    // START samples at mid-bit; every later state samples a full bit period on
    assign sample     = tick && (sub_cnt_q == ((state_q == START) ? SUB_HALF : SUB_LAST));

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx_i};
        rx_prev_d  = rx_s;
        state_d    = state_q;
        tick_cnt_d = tick ? reload : tick_cnt_q - 9'd1;
        sub_cnt_d  = sub_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        push       = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d     = perr_q;
`endif
        if (tick) begin
            sub_cnt_d = sample ? '0 : sub_cnt_q + SW'(1);
        end
        case (state_q)
            IDLE: begin
                tick_cnt_d = reload;
                sub_cnt_d  = '0;
                bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                perr_d     = 1'b0;
`endif
                if (start_edge && ctrl_rxen) state_d = START;
            end
            START: begin
                if (sample) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (sample) begin
                    data_d    = {rx_s, data_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    perr_d  = rx_s ^ (^data_q);
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    push    = ctrl_rxen;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!ctrl_rxen) state_d = IDLE;
    end

    always_comb begin
        push_entry.data = data_q;
        push_entry.ferr = ~rx_s;
`ifdef UART_RX_PARITY_EN
        push_entry.perr = perr_q;
`else
        push_entry.perr = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            sub_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            sub_cnt_q  <= sub_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
`ifdef UART_RX_PARITY_EN
            perr_q     <= perr_d;
`endif
        end
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (data_rd),
        .wdata (push_entry),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign data_fifo = head.data;
    assign data_ferr = head.ferr;
    assign data_perr = head.perr;
    assign stat_rxe  = ~empty;
    assign rx_busy   = (state_q != IDLE);
    assign instat_rx = push & (~full | (data_rd & ~empty));
    assign rx_ovr    = push & ~instat_rx;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised bench for uart_rx_core against a queue-based model of the RX FIFO.
module tb_uart_rx_core;
    localparam int FIFO_DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, rx_i, ctrl_rxen, lpmode_en, data_rd;
    logic [1:0] ctrl_baud;
    logic [7:0] lpmode_div;
    logic [7:0] data_fifo;
    logic       data_ferr, data_perr, stat_rxe, rx_busy, instat_rx, rx_ovr;

    int checks = 0, errors = 0;
    int n_instat = 0, n_ovr = 0;
    int bit_clks = 64;
    logic [9:0] exp_q[$];

    uart_rx_core #(.FIFO_DEPTH(FIFO_DEPTH), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx_i(rx_i), .ctrl_rxen(ctrl_rxen), .ctrl_baud(ctrl_baud),
        .lpmode_en(lpmode_en), .lpmode_div(lpmode_div), .data_rd(data_rd),
        .data_fifo(data_fifo), .data_ferr(data_ferr), .data_perr(data_perr),
        .stat_rxe(stat_rxe), .rx_busy(rx_busy), .instat_rx(instat_rx), .rx_ovr(rx_ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        if (instat_rx) n_instat++;
        if (rx_ovr) n_ovr++;
    end

    function automatic logic [9:0] mk_entry(logic [7:0] d, bit bad_par, bit stop_bit);
        return {PAR & bad_par, ~stop_bit, d};
    endfunction

    function automatic bit model_push(logic [9:0] e);
        if (exp_q.size() >= FIFO_DEPTH) return 1'b1;
        exp_q.push_back(e);
        return 1'b0;
    endfunction

    function automatic logic [10:0] exp_head();
        if (exp_q.size() == 0) return '0;
        return {1'b1, exp_q[0]};
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_bit);
        logic [10:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (PAR) begin
            bits[9] = (^d) ^ bad_par;
            bits[10] = stop_bit;
            nb = 11;
        end else begin
            bits[9] = stop_bit;
            nb = 10;
        end
        for (int i = 0; i < nb; i++) begin
            rx_i = bits[i];
            repeat (bit_clks) @(negedge clk);
        end
        rx_i = 1'b1;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic do_read();
        data_rd = 1'b1;
        @(negedge clk);
        data_rd = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_i = 1'b1; ctrl_rxen = 1'b0; ctrl_baud = 2'd0;
        lpmode_en = 1'b1; lpmode_div = 8'd3; data_rd = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_fifo, data_ferr, data_perr, stat_rxe, rx_busy, instat_rx, rx_ovr} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {data_fifo, data_ferr, data_perr, stat_rxe, rx_busy, instat_rx, rx_ovr});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({stat_rxe, data_perr, data_ferr, data_fifo, rx_busy} !== 12'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got rxe=%b busy=%b data=%h", stat_rxe, rx_busy, data_fifo);
        end
    endtask

    task automatic test_basic();
        int n0;
        ctrl_rxen = 1'b1; lpmode_en = 1'b1; lpmode_div = 8'd3; bit_clks = 64;
        n0 = n_instat;
        send_frame(8'hA5, 1'b0, 1'b1);
        void'(model_push(mk_entry(8'hA5, 1'b0, 1'b1)));
        checks++;
        if ({stat_rxe, data_perr, data_ferr, data_fifo} !== exp_head()) begin
            errors++;
            $display("FAIL basic_head: got %h want %h", {stat_rxe, data_perr, data_ferr, data_fifo}, exp_head());
        end
        checks++;
        if (n_instat - n0 !== 1) begin
            errors++;
            $display("FAIL basic_instat: got %0d pulses want 1", n_instat - n0);
        end
    endtask

    task automatic test_pop();
        do_read();
        checks++;
        if ({stat_rxe, data_perr, data_ferr, data_fifo} !== 11'd0) begin
            errors++;
            $display("FAIL pop_empty: got %h want 0", {stat_rxe, data_perr, data_ferr, data_fifo});
        end
        do_read();
        repeat (2) @(negedge clk);
        checks++;
        if ({stat_rxe, data_perr, data_ferr, data_fifo} !== exp_head()) begin
            errors++;
            $display("FAIL pop_when_empty: got %h want %h", {stat_rxe, data_perr, data_ferr, data_fifo}, exp_head());
        end
    endtask

    task automatic test_errors();
        send_frame(8'h3C, 1'b0, 1'b0);
        void'(model_push(mk_entry(8'h3C, 1'b0, 1'b0)));
        checks++;
        if ({stat_rxe, data_perr, data_ferr, data_fifo} !== exp_head()) begin
            errors++;
            $display("FAIL ferr_head: got %h want %h", {stat_rxe, data_perr, data_ferr, data_fifo}, exp_head());
        end
        do_read();
        send_frame(8'h3C, 1'b1, 1'b1);
        void'(model_push(mk_entry(8'h3C, 1'b1, 1'b1)));
        checks++;
        if ({stat_rxe, data_perr, data_ferr, data_fifo} !== exp_head()) begin
            errors++;
            $display("FAIL perr_head: got %h want %h", {stat_rxe, data_perr, data_ferr, data_fifo}, exp_head());
        end
        do_read();
    endtask

    task automatic test_glitch();
        int n0, done_at;
        bit seen;
        n0 = n_instat; seen = 1'b0; done_at = -1;
        rx_i = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 20) rx_i = 1'b1;
            if (rx_busy) seen = 1'b1;
            else if (seen && done_at < 0) done_at = c;
        end
        checks++;
        if (!(seen && done_at >= 1 && done_at <= 40)) begin
            errors++;
            $display("FAIL glitch_busy: seen=%0d idle_at=%0d want seen=1 idle_at<=40", seen, done_at);
        end
        checks++;
        if (n_instat !== n0 || {stat_rxe, data_perr, data_ferr, data_fifo} !== exp_head()) begin
            errors++;
            $display("FAIL glitch_nopush: pushes=%0d rxe=%b want 0 pushes", n_instat - n0, stat_rxe);
        end
    endtask

    task automatic test_overflow();
        int o0, exp_ovr;
        bit hit;
        o0 = n_ovr; exp_ovr = 0;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b1);
            if (model_push(mk_entry(8'(i), 1'b0, 1'b1))) exp_ovr++;
        end
        checks++;
        if (n_ovr - o0 !== exp_ovr) begin
            errors++;
            $display("FAIL ovr_count: got %0d want %0d", n_ovr - o0, exp_ovr);
        end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            checks++;
            if ({stat_rxe, data_perr, data_ferr, data_fifo} !== exp_head()) begin
                errors++;
                $display("FAIL ovr_read%0d: got %h want %h", k, {stat_rxe, data_perr, data_ferr, data_fifo}, exp_head());
            end
            do_read();
        end
        // Second pass: a read lands on the same cycle as the 9th push
        o0 = n_ovr;
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 1'b0, 1'b1);
            void'(model_push(mk_entry(8'(i), 1'b0, 1'b1)));
        end
        hit = 1'b0;
        fork
            send_frame(8'h09, 1'b0, 1'b1);
            begin
                for (int c = 0; c < 800 && !hit; c++) begin
                    @(negedge clk);
                    if (rx_ovr) begin
                        hit = 1'b1;
                        data_rd = 1'b1;
                        @(negedge clk);
                        data_rd = 1'b0;
                    end
                end
            end
        join
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL ovr_push_cycle: push on full FIFO not observed within 800 clk");
        end else begin
            void'(exp_q.pop_front());
        end
        void'(model_push(mk_entry(8'h09, 1'b0, 1'b1)));
        checks++;
        if (n_ovr - o0 !== 0) begin
            errors++;
            $display("FAIL ovr_with_read: got %0d drops want 0", n_ovr - o0);
        end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            checks++;
            if ({stat_rxe, data_perr, data_ferr, data_fifo} !== exp_head()) begin
                errors++;
                $display("FAIL ovr_rd_read%0d: got %h want %h", k, {stat_rxe, data_perr, data_ferr, data_fifo}, exp_head());
            end
            do_read();
        end
    endtask

    task automatic test_midframe();
        logic [7:0] d, d2;
        int n0;
        d = 8'($urandom); d2 = 8'($urandom);
        send_frame(d, 1'b0, 1'b1);
        void'(model_push(mk_entry(d, 1'b0, 1'b1)));
        n0 = n_instat;
        rx_i = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_i = d2[i];
            repeat (bit_clks) @(negedge clk);
        end
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before: got %b want 1", rx_busy);
        end
        ctrl_rxen = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy_after: got %b want 0", rx_busy);
        end
        rx_i = 1'b1;
        repeat (2 * bit_clks) @(negedge clk);
        ctrl_rxen = 1'b1;
        repeat (bit_clks) @(negedge clk);
        checks++;
        if (n_instat !== n0 || {stat_rxe, data_perr, data_ferr, data_fifo} !== exp_head()) begin
            errors++;
            $display("FAIL mid_retained: pushes=%0d got %h want %h", n_instat - n0, {stat_rxe, data_perr, data_ferr, data_fifo}, exp_head());
        end
        do_read();
    endtask

    task automatic test_random();
        logic [7:0] d;
        int mode, n0, exp_push;
        bit bad_par, stop_bit;
        for (int it = 0; it < 7; it++) begin
            if (it == 6) begin
                lpmode_en = 1'b0; ctrl_baud = 2'd0; bit_clks = 27 * 16;
            end else begin
                lpmode_div = 8'($urandom_range(2, 6));
                bit_clks = (int'(lpmode_div) + 1) * 16;
            end
            d = 8'($urandom);
            mode = $urandom_range(0, 2);
            bad_par = (mode == 1);
            stop_bit = (mode != 2);
            n0 = n_instat;
            send_frame(d, bad_par, stop_bit);
            exp_push = model_push(mk_entry(d, bad_par, stop_bit)) ? 0 : 1;
            checks++;
            if (n_instat - n0 !== exp_push || {stat_rxe, data_perr, data_ferr, data_fifo} !== exp_head()) begin
                errors++;
                $display("FAIL rand%0d: d=%h mode=%0d pushes=%0d got %h want %h", it, d, mode, n_instat - n0, {stat_rxe, data_perr, data_ferr, data_fifo}, exp_head());
            end
            if ($urandom_range(0, 1) == 1) do_read();
        end
        lpmode_en = 1'b1; lpmode_div = 8'd3; bit_clks = 64;
        while (exp_q.size() != 0) begin
            checks++;
            if ({stat_rxe, data_perr, data_ferr, data_fifo} !== exp_head()) begin
                errors++;
                $display("FAIL rand_drain: got %h want %h", {stat_rxe, data_perr, data_ferr, data_fifo}, exp_head());
            end
            do_read();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pop();
        test_errors();
        test_glitch();
        test_overflow();
        test_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
